// File: rtl/boot_pkg.sv
// Shared types and constants for the UART boot loader and its byte packer.
package boot_pkg;

    typedef enum logic [2:0] {
        StHdr,
        StData,
        StChk,
        StRun,
        StErr
    } boot_state_e;

    localparam int unsigned HDR_BYTES = 4;

    function automatic int unsigned bytes_per_word(input int unsigned data_w);
        return data_w / 8;
    endfunction

endpackage

// File: rtl/byte_packer.sv
// Serial byte-to-word assembler: bytes fill lanes little-endian, word_done pulses the
// cycle after the last lane is written.
module byte_packer #(
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              i_reset,
    input  logic [7:0]        data_byte,
    input  logic              valid,
    input  logic              clear,
    output logic [DATA_W-1:0] word,
    output logic              word_done
);
    import boot_pkg::*;

    localparam int unsigned BYTES = bytes_per_word(DATA_W);
    localparam int unsigned IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES - 1);

    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [DATA_W-1:0] word_q, word_d;
    logic              done_q, done_d;

    always_comb begin
        idx_d  = idx_q;
        word_d = word_q;
        done_d = 1'b0;
        if (clear) begin
            idx_d = '0;
        end else if (valid) begin
            for (int i = 0; i < BYTES; i++) begin
                if (idx_q == IDX_W'(i)) word_d[8*i +: 8] = data_byte;
            end
            if (idx_q == LAST_IDX) begin
                idx_d  = '0;
                done_d = 1'b1;
            end else begin
                idx_d = idx_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (i_reset) begin
            idx_q  <= '0;
            word_q <= '0;
            done_q <= 1'b0;
        end else begin
            idx_q  <= idx_d;
            word_q <= word_d;
            done_q <= done_d;
        end
    end

    assign word      = word_q;
    assign word_done = done_q;

endmodule

// File: rtl/uart_boot_loader.sv
// UART boot loader: 4-byte length header, little-endian word writes to RAM, then CPU release.
// Define UART_BOOT_LOADER_CHECKSUM_EN to require a trailing XOR-of-data checksum byte.
module uart_boot_loader #(
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned MAX_WORDS   = 4096,
    parameter int unsigned LOAD_BASE   = 0,
    parameter int unsigned TIMEOUT_CYC = 1000000
) (
    input  logic                           clk,
    input  logic                           i_reset,
    input  logic                           rx_valid,
    input  logic [7:0]                     rx_data,
    output logic                           mem_wr_en,
    output logic [ADDR_W-1:0]              mem_wr_addr,
    output logic [DATA_W-1:0]              mem_wr_data,
    output logic                           cpu_running,
    output logic                           load_error,
    output logic [$clog2(MAX_WORDS+1)-1:0] words_loaded
);
    import boot_pkg::*;

    localparam int unsigned BYTES = bytes_per_word(DATA_W);
    localparam int unsigned CNT_W = $clog2(MAX_WORDS + 1);
    localparam int unsigned REM_W = $clog2(MAX_WORDS * BYTES + 1);
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(LOAD_BASE);
    localparam logic [ADDR_W-1:0] WORD_STEP = ADDR_W'(BYTES);
`ifdef UART_BOOT_LOADER_CHECKSUM_EN
    localparam boot_state_e EMPTY_NEXT = StChk;
`else
    localparam boot_state_e EMPTY_NEXT = StRun;
`endif

    boot_state_e       state_q, state_d;
    logic [1:0]        hdr_cnt_q, hdr_cnt_d;
    logic [23:0]       hdr_q, hdr_d;
    logic [REM_W-1:0]  rem_q, rem_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic [CNT_W-1:0]  words_q, words_d;
    logic [ADDR_W-1:0] off_q, off_d;
`ifdef UART_BOOT_LOADER_CHECKSUM_EN
    logic [7:0]        csum_q, csum_d;
`endif

    logic [31:0]       hdr_n;
    logic              data_acc, tmo_active, tmo_fire;
    logic [DATA_W-1:0] pk_word;
    logic              pk_done;

    assign hdr_n      = {rx_data, hdr_q};
    assign data_acc   = rx_valid && (state_q == StData) && (rem_q != '0);
    assign tmo_active = ((state_q == StHdr) && (hdr_cnt_q != '0)) ||
                        (state_q == StData) || (state_q == StChk);
    assign tmo_fire   = tmo_active && !rx_valid && (tmo_q == TMO_W'(TIMEOUT_CYC - 1));

    byte_packer #(
        .DATA_W(DATA_W)
    ) u_packer (
        .clk      (clk),
        .i_reset  (i_reset),
        .data_byte(rx_data),
        .valid    (data_acc),
        .clear    (state_q != StData),
        .word     (pk_word),
        .word_done(pk_done)
    );

    always_comb begin
        state_d   = state_q;
        hdr_cnt_d = hdr_cnt_q;
        hdr_d     = hdr_q;
        rem_d     = rem_q;
        words_d   = words_q;
        off_d     = off_q;
        tmo_d     = (tmo_active && !rx_valid && !tmo_fire) ? tmo_q + 1'b1 : '0;
`ifdef UART_BOOT_LOADER_CHECKSUM_EN
        csum_d    = data_acc ? (csum_q ^ rx_data) : csum_q;
`endif
        if (pk_done) begin
            words_d = words_q + 1'b1;
            off_d   = off_q + WORD_STEP;
        end
        if (data_acc) rem_d = rem_q - 1'b1;

        unique case (state_q)
            StHdr: begin
                if (rx_valid) begin
                    if (hdr_cnt_q == 2'(HDR_BYTES - 1)) begin
                        hdr_cnt_d = '0;
                        hdr_d     = '0;
                        if (hdr_n == '0) begin
                            state_d = EMPTY_NEXT;
                        end else if (hdr_n > 32'(MAX_WORDS)) begin
                            state_d = StErr;
                        end else begin
                            rem_d   = REM_W'(hdr_n * 32'(BYTES));
                            state_d = StData;
                        end
                    end else begin
                        // Shift in from the top so byte 0 ends up in the low lane.
                        hdr_d     = {rx_data, hdr_q[23:8]};
                        hdr_cnt_d = hdr_cnt_q + 1'b1;
                    end
                end else if (tmo_fire) begin
                    hdr_cnt_d = '0;
                    hdr_d     = '0;
                end
            end
            StData: begin
`ifdef UART_BOOT_LOADER_CHECKSUM_EN
                if (data_acc && (rem_q == REM_W'(1))) state_d = StChk;
`else
                if (pk_done && (rem_q == '0)) state_d = StRun;
`endif
                else if (tmo_fire) state_d = StErr;
            end
`ifdef UART_BOOT_LOADER_CHECKSUM_EN
            StChk: begin
                if (rx_valid) state_d = (rx_data == csum_q) ? StRun : StErr;
                else if (tmo_fire) state_d = StErr;
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (i_reset) begin
            state_q   <= StHdr;
            hdr_cnt_q <= '0;
            hdr_q     <= '0;
            rem_q     <= '0;
            tmo_q     <= '0;
            words_q   <= '0;
            off_q     <= '0;
`ifdef UART_BOOT_LOADER_CHECKSUM_EN
            csum_q    <= '0;
`endif
        end else begin
            state_q   <= state_d;
            hdr_cnt_q <= hdr_cnt_d;
            hdr_q     <= hdr_d;
            rem_q     <= rem_d;
            tmo_q     <= tmo_d;
            words_q   <= words_d;
            off_q     <= off_d;
`ifdef UART_BOOT_LOADER_CHECKSUM_EN
            csum_q    <= csum_d;
`endif
        end
    end

    assign mem_wr_en    = pk_done;
    assign mem_wr_addr  = pk_done ? (BASE_ADDR + off_q) : '0;
    assign mem_wr_data  = pk_done ? pk_word : '0;
    assign cpu_running  = (state_q == StRun);
    assign load_error   = (state_q == StErr);
    assign words_loaded = words_q;

endmodule

// File: tb/tb_uart_boot_loader.sv
// Bench for uart_boot_loader: vector table, reset-mid-load sequence and random images
// checked against a byte-stream model of the load protocol.
module tb_uart_boot_loader;

    localparam int unsigned DATA_W      = 32;
    localparam int unsigned ADDR_W      = 16;
    localparam int unsigned MAX_WORDS   = 4;
    localparam int unsigned LOAD_BASE   = 'h100;
    localparam int unsigned TIMEOUT_CYC = 16;
    localparam int unsigned WL_W        = $clog2(MAX_WORDS + 1);
`ifdef UART_BOOT_LOADER_CHECKSUM_EN
    localparam bit CS_EN = 1'b1;
`else
    localparam bit CS_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              i_reset = 1'b1;
    logic              rx_valid = 1'b0;
    logic [7:0]        rx_data = '0;
    logic              mem_wr_en;
    logic [ADDR_W-1:0] mem_wr_addr;
    logic [DATA_W-1:0] mem_wr_data;
    logic              cpu_running;
    logic              load_error;
    logic [WL_W-1:0]   words_loaded;

    always #5 clk = ~clk;

    uart_boot_loader #(
        .DATA_W     (DATA_W),
        .ADDR_W     (ADDR_W),
        .MAX_WORDS  (MAX_WORDS),
        .LOAD_BASE  (LOAD_BASE),
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .clk         (clk),
        .i_reset     (i_reset),
        .rx_valid    (rx_valid),
        .rx_data     (rx_data),
        .mem_wr_en   (mem_wr_en),
        .mem_wr_addr (mem_wr_addr),
        .mem_wr_data (mem_wr_data),
        .cpu_running (cpu_running),
        .load_error  (load_error),
        .words_loaded(words_loaded)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Write monitor: records strobes, flags wide pulses or strobes while running.
    logic [31:0] got_a[$];
    logic [31:0] got_d[$];
    int   cyc = 0, last_wr = -1, rise = -1, pulse_bad = 0;
    logic prev_wr = 1'b0, prev_run = 1'b0;

    always @(negedge clk) begin
        cyc      <= cyc + 1;
        prev_wr  <= mem_wr_en;
        prev_run <= cpu_running;
        if (i_reset) begin
            got_a.delete();
            got_d.delete();
            pulse_bad <= 0;
            last_wr   <= -1;
            rise      <= -1;
        end else begin
            if (mem_wr_en) begin
                got_a.push_back(32'(mem_wr_addr));
                got_d.push_back(mem_wr_data);
                last_wr <= cyc;
                if (prev_wr || cpu_running) pulse_bad <= pulse_bad + 1;
            end
            if (cpu_running && !prev_run) rise <= cyc;
        end
    end

    logic [7:0]  stim_b[$];
    int          stim_g[$];
    logic [31:0] exp_a[$];
    logic [31:0] exp_d[$];
    bit          exp_run, exp_err;

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        i_reset  = 1'b1;
        rx_valid = 1'b0;
        idle(2);
        i_reset  = 1'b0;
    endtask

    task automatic send_stream();
        for (int i = 0; i < stim_b.size(); i++) begin
            idle(stim_g[i]);
            rx_valid = 1'b1;
            rx_data  = stim_b[i];
            @(posedge clk);
            #1;
            rx_valid = 1'b0;
        end
    endtask

    // Protocol model: walks the byte stream with its idle gaps, no cycle-level detail.
    task automatic model();
        int          ph, hc, k;
        logic [31:0] hv, n, acc;
        logic [7:0]  cs;
        ph = 0; hc = 0; k = 0; hv = 0; n = 0; acc = 0; cs = 0;
        exp_a.delete();
        exp_d.delete();
        for (int i = 0; i < stim_b.size(); i++) begin
            logic [7:0] b;
            b = stim_b[i];
            if (stim_g[i] >= int'(TIMEOUT_CYC)) begin
                if (ph == 0 && hc > 0) begin
                    hc = 0;
                    hv = 0;
                end else if (ph == 1 || ph == 2) begin
                    ph = 4;
                end
            end
            case (ph)
                0: begin
                    hv = hv | (32'(b) << (8 * hc));
                    hc++;
                    if (hc == 4) begin
                        if (hv == 0) ph = CS_EN ? 2 : 3;
                        else if (hv > MAX_WORDS) ph = 4;
                        else begin
                            n = hv; k = 0; acc = 0; ph = 1;
                        end
                        hc = 0;
                        hv = 0;
                    end
                end
                1: begin
                    cs  = cs ^ b;
                    acc = acc | (32'(b) << (8 * (k % 4)));
                    k++;
                    if (k % 4 == 0) begin
                        exp_a.push_back((LOAD_BASE + 4 * (k / 4 - 1)) & 32'hFFFF);
                        exp_d.push_back(acc);
                        acc = 0;
                    end
                    if (k == int'(n) * 4) ph = CS_EN ? 2 : 3;
                end
                2: ph = (b == cs) ? 3 : 4;
                default: ;
            endcase
        end
        if (ph == 1 || ph == 2) ph = 4;
        exp_run = (ph == 3);
        exp_err = (ph == 4);
    endtask

    typedef struct {
        string          name;
        int             nb;
        logic [191:0]   bytes;
        int             gap;
        int             gap_idx;
        int             gap_len;
        int             exp_words;
        bit             exp_run;
        bit             exp_err;
        logic [31:0]    d0;
        logic [31:0]    d1;
    } vec_t;
    vec_t vecs[$];

    task automatic add_vec(input string name, input int nb, input logic [191:0] raw,
                           input int gap, input int gi, input int gl, input int w,
                           input bit r, input bit e, input logic [31:0] d0,
                           input logic [31:0] d1);
        vec_t v;
        v.name = name; v.nb = nb; v.bytes = raw << (8 * (24 - nb));
        v.gap = gap; v.gap_idx = gi; v.gap_len = gl;
        v.exp_words = w; v.exp_run = r; v.exp_err = e; v.d0 = d0; v.d1 = d1;
        vecs.push_back(v);
    endtask

    initial begin
        do_reset();
        check("reset_running", cpu_running, 0);
        check("reset_error", load_error, 0);
        check("reset_words", words_loaded, 0);
        check("reset_wr_en", mem_wr_en, 0);
        check("reset_wr_addr", mem_wr_addr, 0);
        check("reset_wr_data", mem_wr_data, 0);

        add_vec("oversize", 4, 32'h05000000, 1, -1, 0, 0, 0, 1, 0, 0);
        add_vec("huge_n", 4, 32'h00000001, 1, -1, 0, 0, 0, 1, 0, 0);
        add_vec("hdr_gap15_misparse", 10, 80'hAABB_01000000_11223344, 0, 2, 15, 0, 0, 1, 0, 0);
        add_vec("data_tmo", 8, 64'h01000000_11223344, 0, 6, 16, 0, 0, 1, 0, 0);
        add_vec("first_data_tmo", 8, 64'h01000000_11223344, 0, 4, 16, 0, 0, 1, 0, 0);
        add_vec("partial_end", 6, 48'h01000000_1122, 0, -1, 0, 0, 0, 1, 0, 0);
        add_vec("hdr_partial_end", 2, 16'hAABB, 0, -1, 0, 0, 0, 0, 0, 0);
`ifndef UART_BOOT_LOADER_CHECKSUM_EN
        add_vec("normal", 12, 96'h02000000_EFBEADDE_78563412, 2, -1, 0, 2, 1, 0,
                32'hDEADBEEF, 32'h12345678);
        add_vec("back_to_back", 12, 96'h02000000_EFBEADDE_78563412, 0, -1, 0, 2, 1, 0,
                32'hDEADBEEF, 32'h12345678);
        add_vec("empty", 4, 32'h00000000, 1, -1, 0, 0, 1, 0, 0, 0);
        add_vec("hdr_tmo", 10, 80'hAABB_01000000_11223344, 0, 2, 16, 1, 1, 0, 32'h44332211, 0);
        add_vec("data_gap15", 8, 64'h01000000_11223344, 0, 6, 15, 1, 1, 0, 32'h44332211, 0);
        add_vec("max_words", 20, 160'h04000000_00010203_04050607_08090A0B_0C0D0E0F, 0, -1, 0,
                4, 1, 0, 32'h03020100, 32'h07060504);
`else
        add_vec("cs_ok", 9, 72'h01000000_01020408_0F, 1, -1, 0, 1, 1, 0, 32'h08040201, 0);
        add_vec("cs_bad", 9, 72'h01000000_01020408_0E, 1, -1, 0, 1, 0, 1, 32'h08040201, 0);
        add_vec("cs_b2b", 13, 104'h02000000_EFBEADDE_78563412_2A, 0, -1, 0, 2, 1, 0,
                32'hDEADBEEF, 32'h12345678);
        add_vec("cs_empty", 5, 40'h00000000_00, 0, -1, 0, 0, 1, 0, 0, 0);
        add_vec("cs_empty_bad", 5, 40'h00000000_55, 0, -1, 0, 0, 0, 1, 0, 0);
`endif

        foreach (vecs[j]) begin
            vec_t v;
            v = vecs[j];
            stim_b.delete();
            stim_g.delete();
            for (int i = 0; i < v.nb; i++) begin
                stim_b.push_back(v.bytes[191 - 8 * i -: 8]);
                stim_g.push_back((i == v.gap_idx) ? v.gap_len : v.gap);
            end
            do_reset();
            send_stream();
            idle(TIMEOUT_CYC + 6);
            check($sformatf("%s running", v.name), cpu_running, v.exp_run);
            check($sformatf("%s error", v.name), load_error, v.exp_err);
            check($sformatf("%s words", v.name), words_loaded, v.exp_words);
            check($sformatf("%s writes", v.name), got_a.size(), v.exp_words);
            check($sformatf("%s pulses", v.name), pulse_bad, 0);
            if (v.exp_words >= 1 && got_a.size() >= 1) begin
                check($sformatf("%s addr0", v.name), got_a[0], LOAD_BASE);
                check($sformatf("%s data0", v.name), got_d[0], v.d0);
            end
            if (v.exp_words >= 2 && got_a.size() >= 2) begin
                check($sformatf("%s addr1", v.name), got_a[1], LOAD_BASE + 4);
                check($sformatf("%s data1", v.name), got_d[1], v.d1);
            end
            if (!CS_EN && v.exp_run && v.exp_words > 0)
                check($sformatf("%s run_latency", v.name), 64'(rise - last_wr), 1);
        end

        // Reset mid-load, then a full image (trailing 2A is the checksum or an ignored extra).
        stim_b = '{8'h02, 8'h00, 8'h00, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h78, 8'h56};
        stim_g = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        do_reset();
        send_stream();
        idle(2);
        check("midload words", words_loaded, 1);
        i_reset = 1'b1;
        idle(1);
        i_reset = 1'b0;
        check("midreset running", cpu_running, 0);
        check("midreset error", load_error, 0);
        check("midreset words", words_loaded, 0);
        check("midreset wr_en", mem_wr_en, 0);
        stim_b = '{8'h02, 8'h00, 8'h00, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE,
                   8'h78, 8'h56, 8'h34, 8'h12, 8'h2A};
        stim_g = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1};
        send_stream();
        idle(TIMEOUT_CYC + 6);
        check("reload running", cpu_running, 1);
        check("reload writes", got_a.size(), 2);
        if (got_a.size() >= 1) begin
            check("reload addr0", got_a[0], LOAD_BASE);
            check("reload data0", got_d[0], 32'hDEADBEEF);
        end

        // Random images with occasional long gaps, against the protocol model.
        for (int it = 0; it < 40; it++) begin
            int         n;
            logic [7:0] cs, b;
            n  = $urandom_range(0, MAX_WORDS + 1);
            cs = 0;
            stim_b.delete();
            stim_g.delete();
            for (int i = 0; i < 4; i++) stim_b.push_back(8'((n >> (8 * i)) & 'hFF));
            for (int i = 0; i < 4 * n; i++) begin
                b  = 8'($urandom);
                cs = cs ^ b;
                stim_b.push_back(b);
            end
            stim_b.push_back(($urandom_range(0, 3) == 0) ? ~cs : cs);
            for (int i = 0; i < stim_b.size(); i++) stim_g.push_back($urandom_range(0, 3));
            if ($urandom_range(0, 9) < 3)
                stim_g[$urandom_range(0, stim_b.size() - 1)] = $urandom_range(14, 18);
            model();
            do_reset();
            send_stream();
            idle(TIMEOUT_CYC + 6);
            check($sformatf("rand%0d running", it), cpu_running, exp_run);
            check($sformatf("rand%0d error", it), load_error, exp_err);
            check($sformatf("rand%0d words", it), words_loaded, exp_a.size());
            check($sformatf("rand%0d writes", it), got_a.size(), exp_a.size());
            check($sformatf("rand%0d pulses", it), pulse_bad, 0);
            for (int i = 0; i < exp_a.size() && i < got_a.size(); i++) begin
                check($sformatf("rand%0d addr%0d", it, i), got_a[i], exp_a[i]);
                check($sformatf("rand%0d data%0d", it, i), got_d[i], exp_d[i]);
            end
            if (!CS_EN && exp_run && exp_a.size() > 0)
                check($sformatf("rand%0d run_latency", it), 64'(rise - last_wr), 1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
